// File: rtl/mux_selftest_seq_pkg.sv
// Shared types and constants for the 2:1 mux self-test sequencer.
package mux_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int ERR_W       = 5;
    localparam int CNT_W       = 4;

    // Number of the three mux outputs that disagree with the expected value.
    function automatic logic [1:0] mismatch_count(input logic exp,
                                                  input logic y0,
                                                  input logic y1,
                                                  input logic y2);
        mismatch_count = {1'b0, y0 ^ exp} + {1'b0, y1 ^ exp} + {1'b0, y2 ^ exp};
    endfunction

endpackage

// File: rtl/mux_selftest_seq_if.sv
// Bundle of control, stimulus, response and result signals of the sequencer.
interface mux_selftest_seq_if;

    logic                                start;
    logic                                a;
    logic                                b;
    logic                                s0;
    logic                                y0;
    logic                                y1;
    logic                                y2;
    logic                                busy;
    logic                                done;
    logic                                pass;
    logic [mux_test_pkg::ERR_W-1:0]       err_count;
    logic [mux_test_pkg::NUM_VECTORS-1:0] fail_vec;

    modport master (
        input  start, y0, y1, y2,
        output a, b, s0, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, y0, y1, y2,
        input  a, b, s0, busy, done, pass, err_count, fail_vec
    );

endinterface

// File: rtl/mux_selftest_seq_golden.sv
// Reference 2:1 mux: the value every implementation under test must produce.
module mux_golden (
    input  logic a,
    input  logic b,
    input  logic s0,
    output logic y
);

    assign y = s0 ? b : a;

endmodule

// File: rtl/mux_selftest_seq.sv
// Exhaustive self-test sequencer for a 2:1 mux with three implementations;
// walks all 8 input vectors and accumulates per-vector mismatch results.
module mux_selftest_seq
    import mux_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_selftest_seq_if.master   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VECTORS - 1);

    state_t                  state_r, state_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    pass_r, pass_s;
    logic [ERR_W-1:0]        err_r, err_s;
    logic [NUM_VECTORS-1:0]  fail_r, fail_s;
    logic                    exp_s;
    logic [1:0]              miss_s;
    logic [ERR_W-1:0]        err_sum_s;

    // The vector index doubles as the registered stimulus {a,b,s0}.
    mux_golden u_golden (
        .a  (idx_r[2]),
        .b  (idx_r[1]),
        .s0 (idx_r[0]),
        .y  (exp_s)
    );

    assign miss_s    = mismatch_count(exp_s, bus.y0, bus.y1, bus.y2);
    assign err_sum_s = err_r + {{(ERR_W-2){1'b0}}, miss_s};

    // Next-state and next-result logic of the test sequence.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        pass_s  = pass_r;
        err_s   = err_r;
        fail_s  = fail_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_SETTLE;
                    idx_s   = {IDX_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    pass_s  = 1'b0;
                    err_s   = {ERR_W{1'b0}};
                    fail_s  = {NUM_VECTORS{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_CHECK;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            ST_CHECK: begin
                err_s         = err_sum_s;
                fail_s[idx_r] = fail_r[idx_r] | (miss_s != 2'd0);
                // pass includes the last vector, so it is valid alongside done
                if (idx_r == IDX_LAST) begin
                    state_s = ST_DONE;
                    pass_s  = (err_sum_s == {ERR_W{1'b0}});
                end else begin
                    state_s = ST_SETTLE;
                    idx_s   = idx_r + 3'd1;
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                idx_s   = {IDX_W{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = {IDX_W{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= {ERR_W{1'b0}};
            fail_r  <= {NUM_VECTORS{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
            err_r   <= err_s;
            fail_r  <= fail_s;
        end
    end

    assign bus.a         = idx_r[2];
    assign bus.b         = idx_r[1];
    assign bus.s0        = idx_r[0];
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = err_r;
    assign bus.fail_vec  = fail_r;

endmodule
